// File: rtl/vin_pwmmeasure.sv
// vin_pwmmeasure -- PWM period / high-width measurement.
//
// pwm_in goes through a 2-flop synchronizer and a run-length glitch filter.
// The FSM then measures the clk cycles between filtered rising edges and the
// filtered high time within that period.
//
// Ports:
//   clk       in   sole clock, rising edge
//   reset     in   synchronous, active-high
//   pwm_in    in   asynchronous PWM input
//   period    out  [31:0] cycles between the last two filtered rising edges
//   width     out  [31:0] filtered high cycles within that period
//   valid     out  period/width hold a live measurement
//   sample    out  one-cycle strobe on each period/width update
//   timeout   out  sticky flag, set when the measurement is lost
//   dbg_state out  [1:0] FSM state (0 IDLE, 1 HIGH, 2 LOW)
//
// Handshake: there is no back-pressure. sample is a pure one-cycle strobe.
// period/width are stable from the cycle sample is high until the next update.
module vin_pwmmeasure #(
  parameter int unsigned FILTER  = 2,
  parameter int unsigned TIMEOUT = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pwm_in,
  output logic [31:0] period,
  output logic [31:0] width,
  output logic        valid,
  output logic        sample,
  output logic        timeout,
  output logic [1:0]  dbg_state
);

  localparam logic [31:0] TO    = TIMEOUT[31:0];
  localparam logic [8:0]  FILTW = FILTER[8:0];

  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;

  logic        s1_q, s1_d, s2_q, s2_d;
  logic        filt_q, filt_d, prev_q, prev_d;
  logic [7:0]  run_q, run_d;
  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d, w_acc_q, w_acc_d;
  logic [31:0] period_q, period_d, width_q, width_d;
  logic        valid_q, valid_d, sample_q, sample_d, timeout_q, timeout_d;
  logic        rise, fall;
  logic [31:0] cnt_inc;

  // Synchronizer and glitch filter. A run of FILTER samples that differ from
  // the filtered level is needed to flip it; any shorter run restarts.
  always_comb begin
    s1_d   = pwm_in;
    s2_d   = s1_q;
    filt_d = filt_q;
    run_d  = '0;
    if (s2_q != filt_q) begin
      if ({1'b0, run_q} + 9'd1 >= FILTW) begin
        filt_d = s2_q;
      end else begin
        run_d = run_q + 8'd1;
      end
    end
    prev_d = filt_q;
  end

  // Both edges see the same delay, so period and width carry no filter bias.
  assign rise = filt_q & ~prev_q;
  assign fall = ~filt_q & prev_q;

  // cnt saturates at TIMEOUT so it can never wrap.
  assign cnt_inc = (cnt_q < TO) ? cnt_q + 32'd1 : cnt_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_acc_d   = w_acc_q;
    period_d  = period_q;
    width_d   = width_q;
    valid_d   = valid_q;
    sample_d  = 1'b0;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
          cnt_d   = 32'd1;
        end
      end
      HIGH: begin
        // An edge takes priority over a simultaneous timeout.
        if (fall) begin
          w_acc_d = cnt_q;
          cnt_d   = cnt_inc;
          state_d = LOW;
        end else if (cnt_q == TO) begin
          state_d   = IDLE;
          cnt_d     = '0;
          w_acc_d   = '0;
          period_d  = '0;
          width_d   = '0;
          valid_d   = 1'b0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      LOW: begin
        if (rise) begin
          period_d  = cnt_q;
          width_d   = w_acc_q;
          valid_d   = 1'b1;
          sample_d  = 1'b1;
          timeout_d = 1'b0;
          cnt_d     = 32'd1;
          state_d   = HIGH;
        end else if (cnt_q == TO) begin
          state_d   = IDLE;
          cnt_d     = '0;
          w_acc_d   = '0;
          period_d  = '0;
          width_d   = '0;
          valid_d   = 1'b0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      filt_q    <= 1'b0;
      prev_q    <= 1'b0;
      run_q     <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      w_acc_q   <= '0;
      period_q  <= '0;
      width_q   <= '0;
      valid_q   <= 1'b0;
      sample_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      filt_q    <= filt_d;
      prev_q    <= prev_d;
      run_q     <= run_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      w_acc_q   <= w_acc_d;
      period_q  <= period_d;
      width_q   <= width_d;
      valid_q   <= valid_d;
      sample_q  <= sample_d;
      timeout_q <= timeout_d;
    end
  end

  assign period    = period_q;
  assign width     = width_q;
  assign valid     = valid_q;
  assign sample    = sample_q;
  assign timeout   = timeout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vin_pwmmeasure.sv
// Directed bench for vin_pwmmeasure with FILTER=2, TIMEOUT=1000.
module tb_vin_pwmmeasure;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pwm_in = 1'b0;
  logic [31:0] period, width;
  logic        valid, sample, timeout;
  logic [1:0]  dbg_state;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Event log gathered on the falling edge, away from the active edge.
  int cyc = 0;
  int n_samp = 0;
  int last_samp_cyc = 0;
  int to_cyc = 0;
  int n_to_rise = 0;
  int n_dbl = 0;
  logic samp_prev = 1'b0;
  logic to_prev = 1'b0;
  int base;

  vin_pwmmeasure #(.FILTER(2), .TIMEOUT(1000)) dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in),
    .period(period), .width(width), .valid(valid), .sample(sample),
    .timeout(timeout), .dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (sample) begin
      n_samp = n_samp + 1;
      last_samp_cyc = cyc;
    end
    if (sample && samp_prev) n_dbl = n_dbl + 1;
    if (timeout && !to_prev) begin
      to_cyc = cyc;
      n_to_rise = n_to_rise + 1;
    end
    samp_prev = sample;
    to_prev = timeout;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    pwm_in = lvl;
    step(n);
  endtask

  // One PWM period; glitch puts a 1-cycle low pulse inside the high phase.
  task automatic pwm_period(input int hi, input int per, input bit glitch);
    for (int i = 0; i < per; i++) begin
      pwm_in = (i < hi);
      if (glitch && i == 10) pwm_in = 1'b0;
      step(1);
    end
  endtask

  task automatic do_reset(input logic lvl, input int n);
    pwm_in = lvl;
    reset = 1'b1;
    step(n);
    reset = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset(1'b0, 5);
    chk("rst_period", period, 0);
    chk("rst_width", width, 0);
    chk("rst_valid", {31'd0, valid}, 0);
    chk("rst_sample", {31'd0, sample}, 0);
    chk("rst_timeout", {31'd0, timeout}, 0);
    chk("rst_state", {30'd0, dbg_state}, 0);

    // four clean periods: the first rise only arms, then three samples
    base = n_samp;
    for (int p = 0; p < 4; p++) pwm_period(25, 100, 1'b0);
    chk("a_samples", n_samp - base, 3);
    chk("a_period", period, 100);
    chk("a_width", width, 25);
    chk("a_valid", {31'd0, valid}, 1);
    chk("a_timeout", {31'd0, timeout}, 0);

    // same stream with short glitches in the high phase
    base = n_samp;
    for (int p = 0; p < 3; p++) pwm_period(25, 100, 1'b1);
    chk("b_samples", n_samp - base, 3);
    chk("b_period", period, 100);
    chk("b_width", width, 25);
    chk("b_single_strobe", n_dbl, 0);

    // input stops low: timeout exactly 1000 cycles after the last sample
    hold(1'b0, 1200);
    chk("c_timeout", {31'd0, timeout}, 1);
    chk("c_to_delay", to_cyc - last_samp_cyc, 1000);
    chk("c_valid", {31'd0, valid}, 0);
    chk("c_period", period, 0);
    chk("c_width", width, 0);
    chk("c_state", {30'd0, dbg_state}, 0);
    base = n_samp;
    pwm_period(25, 100, 1'b0);
    pwm_period(25, 100, 1'b0);
    hold(1'b0, 10);
    chk("c_resume_samples", n_samp - base, 1);
    chk("c_resume_valid", {31'd0, valid}, 1);
    chk("c_resume_timeout", {31'd0, timeout}, 0);
    chk("c_resume_period", period, 100);

    // reset in the middle of a period
    pwm_period(25, 50, 1'b0);
    do_reset(1'b0, 1);
    chk("d_period", period, 0);
    chk("d_width", width, 0);
    chk("d_valid", {31'd0, valid}, 0);
    chk("d_timeout", {31'd0, timeout}, 0);
    base = n_samp;
    pwm_period(25, 100, 1'b0);
    chk("d_no_early_sample", n_samp - base, 0);
    pwm_period(25, 100, 1'b0);
    chk("d_first_sample", n_samp - base, 1);
    chk("d_period_after", period, 100);

    // input high across reset release, constant high until timeout
    do_reset(1'b1, 3);
    base = n_samp;
    hold(1'b1, 1500);
    chk("e_samples_high", n_samp - base, 0);
    chk("e_valid_high", {31'd0, valid}, 0);
    chk("e_timeout_high", {31'd0, timeout}, 1);
    chk("e_period_high", period, 0);
    chk("e_width_high", width, 0);
    hold(1'b0, 100);
    pwm_period(60, 200, 1'b0);
    pwm_period(60, 200, 1'b0);
    hold(1'b0, 10);
    chk("e_samples", n_samp - base, 1);
    chk("e_period", period, 200);
    chk("e_width", width, 60);
    chk("e_timeout_clr", {31'd0, timeout}, 0);

    // rises exactly TIMEOUT apart: the edge must win
    base = n_samp;
    n_to_rise = 0;
    for (int p = 0; p < 3; p++) pwm_period(100, 1000, 1'b0);
    chk("f_samples", n_samp - base, 3);
    chk("f_period", period, 1000);
    chk("f_width", width, 100);
    chk("f_valid", {31'd0, valid}, 1);
    chk("f_timeout", {31'd0, timeout}, 0);
    chk("f_no_timeout_event", n_to_rise, 0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
